// File: rtl/autocorr_pkg.sv
// Shared constants and types for the autocorrelation stage and its consumers.
package autocorr_pkg;

  localparam int N_SAMPLES  = 480;
  localparam int ACC_W      = 71;
  localparam int CENTER_IDX = N_SAMPLES - 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [9:0]              lag_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_R0,
    SCAN,
    FLUSH,
    DECIDE,
    DONE
  } pick_state_t;

endpackage

// File: rtl/autocorr_pitch_picker_if.sv
// Bundle for the pitch picker: start/busy/done handshake, result-array
// read port and the pitch results. The master side is the picker.
interface autocorr_pitch_picker_if;
  import autocorr_pkg::*;

  logic start;
  logic busy;
  logic done;
  logic rd_en;
  lag_t rd_addr;
  acc_t rd_data;
  lag_t peak_lag;
  acc_t peak_val;
  acc_t r0_val;
  logic voiced;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, peak_lag, peak_val, r0_val, voiced
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, peak_lag, peak_val, r0_val, voiced
  );

endinterface

// File: rtl/autocorr_pitch_picker_running_max.sv
// Signed running-maximum register with a tag. The first valid sample of a
// run always loads; later samples replace it only when strictly greater, so
// ties keep the earliest tag. Also usable as a peak-hold meter.
module autocorr_pitch_picker_running_max
  import autocorr_pkg::*;
(
  input  logic clk,
  input  logic load_first,
  input  logic valid,
  input  acc_t value,
  input  lag_t tag,
  output acc_t max_val,
  output lag_t max_tag
);

  // Load on the first sample of a run or on a strictly larger value
  always_ff @(posedge clk) begin
    if (valid && (load_first || (value > max_val))) begin
      max_val <= value;
      max_tag <= tag;
    end
  end

endmodule

// File: rtl/autocorr_pitch_picker.sv
// Pitch picker: reads R[0] and R[MIN_LAG..MAX_LAG] from the autocorrelation
// result array, tracks the largest lag value and makes a voiced decision
// from the ratio of that peak to the zero-lag energy.
module autocorr_pitch_picker
  import autocorr_pkg::*;
#(
  parameter int MIN_LAG    = 20,
  parameter int MAX_LAG    = 400,
  parameter int THRESH_NUM = 3
) (
  input logic                     Clk,
  input logic                     Reset_n,
  autocorr_pitch_picker_if.master bus
);

  localparam lag_t SCAN_LAST  = lag_t'(MAX_LAG - MIN_LAG);
  localparam lag_t ADDR_R0    = lag_t'(CENTER_IDX);
  localparam lag_t ADDR_FIRST = lag_t'(CENTER_IDX + MIN_LAG);
  localparam lag_t LAG_FIRST  = lag_t'(MIN_LAG);
  localparam int   WIDE_W     = ACC_W + 4;

  typedef logic signed [WIDE_W-1:0] wide_t;

  localparam wide_t THRESH_W = wide_t'(THRESH_NUM);

  // Sign-extend into the headroom width so 8*x cannot overflow
  function automatic wide_t widen(acc_t v);
    wide_t w;
    w = wide_t'(v);
    return w;
  endfunction

  function automatic wide_t times8(acc_t v);
    return widen(v) <<< 3;
  endfunction

  function automatic wide_t times_thresh(acc_t v);
    return widen(v) * THRESH_W;
  endfunction

  // Voiced only with positive energy and peak/R0 >= THRESH_NUM/8 (inclusive)
  function automatic logic is_voiced(acc_t pk, acc_t r0);
    logic r0_pos;
    r0_pos = !r0[ACC_W-1] && (r0 != '0);
    return r0_pos && (times8(pk) >= times_thresh(r0));
  endfunction

  pick_state_t state;
  pick_state_t state_nxt;
  lag_t        scan_cnt;

  logic        fetch_vld_p0;
  logic        scan_vld_p0;
  logic        first_p0;
  lag_t        tag_p0;

  acc_t        r0_p1;
  acc_t        max_val;
  lag_t        max_tag;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: start only honoured in IDLE, scan length fixed by the window
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.start) state_nxt = FETCH_R0;
      FETCH_R0: state_nxt = SCAN;
      SCAN:     if (scan_cnt == SCAN_LAST) state_nxt = FLUSH;
      FLUSH:    state_nxt = DECIDE;
      DECIDE:   state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    bus.rd_en = (state == FETCH_R0) || (state == SCAN);
    bus.busy  = (state == FETCH_R0) || (state == SCAN) ||
                (state == FLUSH)    || (state == DECIDE);
    bus.done  = (state == DONE);
  end

  // Read address and scan index; address holds while reads are idle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scan_cnt    <= '0;
      bus.rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) bus.rd_addr <= ADDR_R0;
        end
        FETCH_R0: begin
          scan_cnt    <= '0;
          bus.rd_addr <= ADDR_FIRST;
        end
        SCAN: begin
          if (scan_cnt != SCAN_LAST) begin
            scan_cnt    <= scan_cnt + 10'd1;
            bus.rd_addr <= bus.rd_addr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: rd_data arrives one cycle after the read; mark what it is
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_vld_p0 <= 1'b0;
      scan_vld_p0  <= 1'b0;
      first_p0     <= 1'b0;
    end else begin
      fetch_vld_p0 <= (state == FETCH_R0);
      scan_vld_p0  <= (state == SCAN);
      first_p0     <= (state == SCAN) && (scan_cnt == '0);
    end
  end

  // Stage p0: lag tag travelling with the returning data
  always_ff @(posedge Clk) begin
    tag_p0 <= LAG_FIRST + scan_cnt;
  end

  // Stage p1: hold zero-lag energy for the decision
  always_ff @(posedge Clk) begin
    if (fetch_vld_p0) r0_p1 <= bus.rd_data;
  end

  autocorr_pitch_picker_running_max u_running_max (
    .clk        (Clk),
    .load_first (first_p0),
    .valid      (scan_vld_p0),
    .value      (bus.rd_data),
    .tag        (tag_p0),
    .max_val    (max_val),
    .max_tag    (max_tag)
  );

  // Result registers: updated once per block in DECIDE, held otherwise
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.peak_lag <= '0;
      bus.peak_val <= '0;
      bus.r0_val   <= '0;
      bus.voiced   <= 1'b0;
    end else if (state == DECIDE) begin
      bus.peak_lag <= max_tag;
      bus.peak_val <= max_val;
      bus.r0_val   <= r0_p1;
      bus.voiced   <= is_voiced(max_val, r0_p1);
    end
  end

endmodule

// File: tb/tb_autocorr_pitch_picker.sv
// Directed bench for autocorr_pitch_picker: a behavioural result array
// answers reads one cycle later and drives a large decoy value otherwise.
module tb_autocorr_pitch_picker;
  import autocorr_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  autocorr_pitch_picker_if bus();
  autocorr_pitch_picker_if bus_k0();

  autocorr_pitch_picker #(.MIN_LAG(20), .MAX_LAG(400), .THRESH_NUM(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  autocorr_pitch_picker #(.MIN_LAG(50), .MAX_LAG(50), .THRESH_NUM(3)) dut_k0 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_k0)
  );

  localparam acc_t DECOY   = acc_t'(64'sh1000_0000_0000_0000);
  localparam acc_t OUTSIDE = acc_t'(64'sh0100_0000_0000_0000);

  acc_t mem [0:958];
  int   checks = 0;
  int   fails  = 0;

  always @(posedge Clk) begin
    bus.rd_data    <= bus.rd_en    ? mem[bus.rd_addr]    : DECOY;
    bus_k0.rd_data <= bus_k0.rd_en ? mem[bus_k0.rd_addr] : DECOY;
  end

  task automatic fill(input acc_t r0, input acc_t other);
    for (int i = 0; i < 959; i++) mem[i] = OUTSIDE;
    mem[CENTER_IDX] = r0;
    for (int l = 20; l <= 400; l++) mem[CENTER_IDX + l] = other;
  endtask

  task automatic run_block(output int lat);
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 1000) begin
      @(negedge Clk); lat++;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; bus.start = 1'b0; bus_k0.start = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (bus.rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %0b want 0", bus.rd_en); end
    checks++; if (bus.rd_addr !== 10'd0) begin fails++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    checks++; if (bus.peak_lag !== 10'd0) begin fails++; $display("FAIL reset_peak_lag: got %0d want 0", bus.peak_lag); end
    checks++; if (bus.peak_val !== acc_t'(0)) begin fails++; $display("FAIL reset_peak_val: got %0d want 0", bus.peak_val); end
    checks++; if (bus.r0_val !== acc_t'(0)) begin fails++; $display("FAIL reset_r0_val: got %0d want 0", bus.r0_val); end
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL reset_voiced: got %0b want 0", bus.voiced); end
    @(negedge Clk); Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_single_peak;
    int lat;
    fill(acc_t'(1000), acc_t'(0)); mem[CENTER_IDX + 150] = acc_t'(900);
    run_block(lat);
    checks++; if (lat !== 385) begin fails++; $display("FAIL single_latency: got %0d want 385", lat); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_at_done: got %0b want 0", bus.busy); end
    checks++; if (bus.peak_lag !== 10'd150) begin fails++; $display("FAIL single_peak_lag: got %0d want 150", bus.peak_lag); end
    checks++; if (bus.peak_val !== acc_t'(900)) begin fails++; $display("FAIL single_peak_val: got %0d want 900", bus.peak_val); end
    checks++; if (bus.r0_val !== acc_t'(1000)) begin fails++; $display("FAIL single_r0_val: got %0d want 1000", bus.r0_val); end
    checks++; if (bus.voiced !== 1'b1) begin fails++; $display("FAIL single_voiced: got %0b want 1", bus.voiced); end
    @(negedge Clk);
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %0b want 0", bus.done); end
    checks++; if (bus.peak_lag !== 10'd150) begin fails++; $display("FAIL single_hold_lag: got %0d want 150", bus.peak_lag); end
  endtask

  task automatic test_tie_threshold;
    int lat;
    fill(acc_t'(1000), acc_t'(-5));
    mem[CENTER_IDX + 60] = acc_t'(374); mem[CENTER_IDX + 120] = acc_t'(374);
    run_block(lat);
    checks++; if (bus.peak_lag !== 10'd60) begin fails++; $display("FAIL tie_peak_lag: got %0d want 60", bus.peak_lag); end
    checks++; if (bus.peak_val !== acc_t'(374)) begin fails++; $display("FAIL tie_peak_val: got %0d want 374", bus.peak_val); end
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL tie_below_thresh: got %0b want 0", bus.voiced); end
    mem[CENTER_IDX + 60] = acc_t'(375); mem[CENTER_IDX + 120] = acc_t'(375);
    run_block(lat);
    checks++; if (bus.peak_lag !== 10'd60) begin fails++; $display("FAIL tie2_peak_lag: got %0d want 60", bus.peak_lag); end
    checks++; if (bus.voiced !== 1'b1) begin fails++; $display("FAIL tie_at_thresh: got %0b want 1", bus.voiced); end
  endtask

  task automatic test_all_negative;
    int lat;
    fill(acc_t'(500), acc_t'(0));
    for (int l = 20; l <= 400; l++) mem[CENTER_IDX + l] = acc_t'(-l);
    run_block(lat);
    checks++; if (bus.peak_lag !== 10'd20) begin fails++; $display("FAIL neg_peak_lag: got %0d want 20", bus.peak_lag); end
    checks++; if (bus.peak_val !== acc_t'(-20)) begin fails++; $display("FAIL neg_peak_val: got %0d want -20", bus.peak_val); end
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL neg_voiced: got %0b want 0", bus.voiced); end
  endtask

  task automatic test_nonpositive_energy;
    int lat;
    fill(acc_t'(0), acc_t'(0)); mem[CENTER_IDX + 200] = acc_t'(50);
    run_block(lat);
    checks++; if (bus.peak_lag !== 10'd200) begin fails++; $display("FAIL r0zero_peak_lag: got %0d want 200", bus.peak_lag); end
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL r0zero_voiced: got %0b want 0", bus.voiced); end
    fill(acc_t'(-100), acc_t'(0)); mem[CENTER_IDX + 33] = acc_t'(10);
    run_block(lat);
    checks++; if (bus.peak_lag !== 10'd33) begin fails++; $display("FAIL r0neg_peak_lag: got %0d want 33", bus.peak_lag); end
    checks++; if (bus.r0_val !== acc_t'(-100)) begin fails++; $display("FAIL r0neg_r0_val: got %0d want -100", bus.r0_val); end
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL r0neg_voiced: got %0b want 0", bus.voiced); end
  endtask

  task automatic test_wide_threshold;
    int   lat;
    acc_t r0_big;
    acc_t pk;
    r0_big = acc_t'(1) <<< 69;
    pk     = acc_t'(1) <<< 68;
    fill(r0_big, acc_t'(0)); mem[CENTER_IDX + 300] = pk;
    run_block(lat);
    checks++; if (bus.peak_val !== pk) begin fails++; $display("FAIL wide_peak_val: got %0d want %0d", bus.peak_val, pk); end
    checks++; if (bus.voiced !== 1'b1) begin fails++; $display("FAIL wide_voiced_hi: got %0b want 1", bus.voiced); end
    pk = (acc_t'(3) <<< 66) - acc_t'(1);
    mem[CENTER_IDX + 300] = pk;
    run_block(lat);
    checks++; if (bus.voiced !== 1'b0) begin fails++; $display("FAIL wide_voiced_just_below: got %0b want 0", bus.voiced); end
  endtask

  task automatic test_protocol;
    int   busy_bad, addr_bad, ndone, done_at;
    lag_t exp_addr;
    logic exp_en, exp_busy;
    fill(acc_t'(1000), acc_t'(0)); mem[CENTER_IDX + 150] = acc_t'(900);
    busy_bad = 0; addr_bad = 0; ndone = 0; done_at = 0;
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk);
    for (int c = 1; c <= 405; c++) begin
      exp_busy = (c <= 384);
      exp_en   = (c <= 382);
      if (c == 1)        exp_addr = 10'd479;
      else if (c <= 382) exp_addr = lag_t'(497 + c);
      else               exp_addr = 10'd879;
      if (bus.busy !== exp_busy) busy_bad++;
      if (bus.rd_en !== exp_en || bus.rd_addr !== exp_addr) addr_bad++;
      if (bus.done === 1'b1) begin ndone++; done_at = c; end
      bus.start = (c == 10 || c == 385);
      @(negedge Clk);
    end
    bus.start = 1'b0;
    checks++; if (busy_bad !== 0) begin fails++; $display("FAIL proto_busy: got %0d bad cycles want 0", busy_bad); end
    checks++; if (addr_bad !== 0) begin fails++; $display("FAIL proto_rd_addr: got %0d bad cycles want 0", addr_bad); end
    checks++; if (ndone !== 1) begin fails++; $display("FAIL proto_done_count: got %0d want 1", ndone); end
    checks++; if (done_at !== 385) begin fails++; $display("FAIL proto_done_cycle: got %0d want 385", done_at); end
    checks++; if (bus.peak_lag !== 10'd150) begin fails++; $display("FAIL proto_peak_lag: got %0d want 150", bus.peak_lag); end
  endtask

  task automatic test_reset_mid_scan;
    int lat, ndone;
    fill(acc_t'(1000), acc_t'(-5));
    mem[CENTER_IDX + 60] = acc_t'(375); mem[CENTER_IDX + 120] = acc_t'(375);
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
    repeat (99) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++; if ({bus.rd_en, bus.busy, bus.done, bus.voiced} !== 4'b0) begin fails++; $display("FAIL midrst_ctrl: got %b want 0000", {bus.rd_en, bus.busy, bus.done, bus.voiced}); end
    checks++; if ({bus.rd_addr, bus.peak_lag} !== 20'd0) begin fails++; $display("FAIL midrst_addr_lag: got %0d/%0d want 0/0", bus.rd_addr, bus.peak_lag); end
    checks++; if (bus.peak_val !== acc_t'(0) || bus.r0_val !== acc_t'(0)) begin fails++; $display("FAIL midrst_vals: got %0d/%0d want 0/0", bus.peak_val, bus.r0_val); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 400; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      @(negedge Clk);
    end
    checks++; if (ndone !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d active cycles want 0", ndone); end
    run_block(lat);
    checks++; if (lat !== 385) begin fails++; $display("FAIL midrst_restart_latency: got %0d want 385", lat); end
    checks++; if (bus.peak_lag !== 10'd60 || bus.voiced !== 1'b1) begin fails++; $display("FAIL midrst_restart_result: got lag %0d voiced %0b want lag 60 voiced 1", bus.peak_lag, bus.voiced); end
  endtask

  task automatic test_single_lag_window;
    int lat;
    fill(acc_t'(1000), acc_t'(0)); mem[CENTER_IDX + 50] = acc_t'(400);
    @(negedge Clk); bus_k0.start = 1'b1;
    @(negedge Clk); bus_k0.start = 1'b0;
    lat = 1;
    while (bus_k0.done !== 1'b1 && lat < 100) begin
      @(negedge Clk); lat++;
    end
    checks++; if (lat !== 5) begin fails++; $display("FAIL k0_latency: got %0d want 5", lat); end
    checks++; if (bus_k0.peak_lag !== 10'd50) begin fails++; $display("FAIL k0_peak_lag: got %0d want 50", bus_k0.peak_lag); end
    checks++; if (bus_k0.peak_val !== acc_t'(400)) begin fails++; $display("FAIL k0_peak_val: got %0d want 400", bus_k0.peak_val); end
    checks++; if (bus_k0.voiced !== 1'b1) begin fails++; $display("FAIL k0_voiced: got %0b want 1", bus_k0.voiced); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL k0_main_idle: got %0b want 0", bus.busy); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus_k0.start = 1'b0;
    test_reset();
    test_single_peak();
    test_tie_threshold();
    test_all_negative();
    test_nonpositive_energy();
    test_wide_threshold();
    test_protocol();
    test_reset_mid_scan();
    test_single_lag_window();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/autocorr_pitch_picker.md
Name: autocorr_pitch_picker

Overview:
- Downstream consumer of the autoConvolution stage. After each 480-sample block has been correlated, it scans the stored autocorrelation result array and finds the lag with the largest correlation inside a configurable pitch window.
- It reports that lag, its value, and a voiced/unvoiced decision based on the ratio to the zero-lag energy R[0].
- The output feeds the pitch/tuner display logic.

Parameters:
- N_SAMPLES, 480: samples per block; the result array holds 2*N_SAMPLES-1 = 959 entries.
- ACC_W, 71: signed width of each autocorrelation word.
- CENTER_IDX, 479: array index of lag 0. Lag L is stored at CENTER_IDX+L.
- MIN_LAG, 20: first lag scanned (2.4 kHz at 48 kHz).
- MAX_LAG, 400: last lag scanned (120 Hz). Legal range is 1 <= MIN_LAG <= MAX_LAG <= N_SAMPLES-1.
- THRESH_NUM, 3: voiced when 8*peak_val >= THRESH_NUM*R[0] (range 0..8).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the autoConvolution Done signal.
- rd_en  out  1  read strobe into the result array.
- rd_addr  out  10  result-array index.
- rd_data  in  ACC_W  signed word. It is valid exactly one cycle after rd_en.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- peak_lag  out  10  lag of the maximum.
- peak_val  out  ACC_W  signed R[peak_lag].
- r0_val  out  ACC_W  R[0].
- voiced  out  1  threshold decision.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0: rd_en=0, rd_addr=0, busy=0, done=0, peak_lag=0, peak_val=0, r0_val=0, voiced=0.
- States: IDLE, FETCH_R0, SCAN, FLUSH, DECIDE, DONE.
- Let K = MAX_LAG-MIN_LAG, and let T be the cycle in which start is sampled high in IDLE.
- T+1 (FETCH_R0): rd_en=1, rd_addr=CENTER_IDX.
- T+2..T+2+K (SCAN):
  - rd_en=1, rd_addr=CENTER_IDX+MIN_LAG+i in cycle T+2+i.
  - R0 data is captured in T+2.
  - Lag data is captured in T+3..T+3+K; the last capture happens in FLUSH.
- Compare rule: a running max is held in a register with a lag tag.
  - The first scanned lag always loads it.
  - Later lags replace it only if strictly greater (signed compare).
  - On ties the earliest lag wins.
- T+4+K (DECIDE): rd_en=0. Compute the voiced decision and register all results.
  - Form 8*peak_val and THRESH_NUM*R0 in ACC_W+4 bits, sign-extended.
  - voiced = (R0 > 0) && (8*peak_val >= THRESH_NUM*R0).
  - If R0 <= 0, voiced=0.
- T+5+K (DONE): done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE. With default parameters, done arrives at T+385.
- Result outputs hold their values until the next DECIDE. They are not cleared by a new start.
- start while busy: ignored, with no effect on the scan in progress. start in the DONE cycle is also ignored. start is accepted only in IDLE.
- rd_addr holds its last value whenever rd_en=0.
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0. No done is issued.
- rd_data is sampled only in the cycle after rd_en. Values on rd_data in other cycles do not affect results.
- MIN_LAG == MAX_LAG: K=0, a single lag is scanned, and done arrives at T+5.

Decomposition:
- Shared package autocorr_pkg holds:
  - ACC_W, N_SAMPLES, CENTER_IDX constants, shared with autoConvolution.
  - typedef acc_t (logic signed [ACC_W-1:0]).
  - typedef lag_t (logic [9:0]).
  - enum pick_state_t.
- One natural sub-module, running_max: a signed compare/load register with a tag. It has inputs load_first, valid, value and tag, and outputs max_val and max_tag. This unit is reusable for peak-hold metering.

Test Plan:
- Single peak: R0=1000, R[150]=900, all other scanned lags 0. start -> done at T+385 with peak_lag=150, peak_val=900, r0_val=1000, voiced=1 (7200 >= 3000).
- Tie and threshold: R0=1000, R[60]=R[120]=374, others -5. Expect peak_lag=60 (earliest wins). voiced=0 because 2992 < 3000. Change both to 375: voiced=1, since the threshold is inclusive.
- All negative window: R0=500, lags 20..400 hold -(lag). Expect peak_lag=20, peak_val=-20, voiced=0.
- Non-positive energy: R0=0, R[200]=50. Expect peak_lag=200, voiced=0.
- Protocol: pulse start again at T+10 and at T+385 (the done cycle). Neither is accepted: exactly one done, busy stays high T+1..T+384, and rd_addr follows 479, then 499..879, incrementing by 1.
- Reset mid-scan: drop Reset_n at T+100 for 2 cycles. All outputs go to 0 immediately and no done occurs. A new start afterwards yields done 385 cycles later with correct results.
